// File: rtl/axis_packet_fifo.sv
// Store-and-forward AXI-Stream packet FIFO: a packet's beats are presented downstream only once its
// tlast beat is stored, except for oversize packets that fill the FIFO and fall back to cut-through.
module axis_packet_fifo #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 32,
    parameter int unsigned AddrWidth = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DataWidth-1:0] s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    output logic [DataWidth-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic [AddrWidth:0]   fill_level,
    output logic [AddrWidth:0]   pkt_count,
    output logic                 cut_through
);

    localparam int unsigned PtrWidth = AddrWidth + 1;

    typedef enum logic {
        ST_STORE = 1'b0,
        ST_CUT   = 1'b1
    } state_t;

    logic [DataWidth:0]  r_mem [Depth];
    logic [PtrWidth-1:0] r_wr_ptr;
    logic [PtrWidth-1:0] r_rd_ptr;
    logic [PtrWidth-1:0] r_pkt_count;
    state_t              r_state;
    state_t              w_state_nxt;

    logic [PtrWidth-1:0] w_fill;
    logic                w_full;
    logic                w_empty;
    logic                w_wr_en;
    logic                w_rd_en;
    logic                w_wr_last;
    logic                w_rd_last;
    logic [DataWidth:0]  w_rd_word;

    // Status and handshakes depend only on registered state, never on the partner's valid/ready.
    assign w_fill        = r_wr_ptr - r_rd_ptr;
    assign w_full        = (w_fill == PtrWidth'(Depth));
    assign w_empty       = (w_fill == '0);
    assign w_rd_word     = r_mem[r_rd_ptr[AddrWidth-1:0]];

    assign s_axis_tready = !w_full;
    assign m_axis_tvalid = !w_empty && ((r_pkt_count != '0) || (r_state == ST_CUT));
    assign m_axis_tdata  = w_rd_word[DataWidth-1:0];
    assign m_axis_tlast  = w_rd_word[DataWidth];
    assign fill_level    = w_fill;
    assign pkt_count     = r_pkt_count;
    assign cut_through   = (r_state == ST_CUT);

    assign w_wr_en   = s_axis_tvalid && s_axis_tready;
    assign w_rd_en   = m_axis_tvalid && m_axis_tready;
    assign w_wr_last = w_wr_en && s_axis_tlast;
    assign w_rd_last = w_rd_en && m_axis_tlast;

    // Payload storage is not reset; reset only discards it by clearing the pointers.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AddrWidth-1:0]] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_pkt_count <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PtrWidth'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PtrWidth'(1);
            end
            case ({w_wr_last, w_rd_last})
                2'b10:   r_pkt_count <= r_pkt_count + PtrWidth'(1);
                2'b01:   r_pkt_count <= r_pkt_count - PtrWidth'(1);
                default: r_pkt_count <= r_pkt_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_STORE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A full FIFO with no complete packet would deadlock, so release the oversize packet as it arrives.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_STORE: begin
                if (w_full && (r_pkt_count == '0)) begin
                    w_state_nxt = ST_CUT;
                end
            end
            ST_CUT: begin
                if (w_rd_last) begin
                    w_state_nxt = ST_STORE;
                end
            end
            default: w_state_nxt = ST_STORE;
        endcase
    end

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Bench for axis_packet_fifo: table-driven single packet, directed corner sequences and random
// traffic, all checked against a queue-based packet FIFO model.
module tb_axis_packet_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;

    logic          clk;
    logic          reset;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [AW:0]   fill_level;
    logic [AW:0]   pkt_count;
    logic          cut_through;

    axis_packet_fifo #(.DataWidth(DW), .Depth(DEPTH), .AddrWidth(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .fill_level    (fill_level),
        .pkt_count     (pkt_count),
        .cut_through   (cut_through)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the stored words as a queue of {tlast,tdata}, plus the cut-through flag.
    logic [DW:0] q[$];
    bit          m_cut;
    logic [DW:0] in_log[$];
    logic [DW:0] out_log[$];
    bit          did_wr;
    bit          did_rd;

    typedef struct {
        logic          vin;
        logic [DW-1:0] d;
        logic          l;
        logic          rdy;
        logic          e_vld;
        logic [DW-1:0] e_data;
        logic          e_last;
        logic [AW:0]   e_fill;
        logic [AW:0]   e_pkt;
    } vec_t;

    vec_t tbl[33];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lastcnt();
        int n = 0;
        foreach (q[i]) if (q[i][DW]) n++;
        return n;
    endfunction

    // One clock cycle: drive, compare against the model before the edge, then advance the model.
    task automatic step(input logic vin, input logic [DW-1:0] d, input logic l, input logic rdy);
        bit          exp_rdy;
        bit          exp_vld;
        bit          nxt_cut;
        logic [DW:0] front;
        s_axis_tvalid = vin;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        m_axis_tready = rdy;
        #1;
        exp_rdy = (q.size() < DEPTH);
        exp_vld = (q.size() != 0) && ((lastcnt() != 0) || m_cut);
        front   = (q.size() != 0) ? q[0] : '0;
        chk("s_tready", 64'(s_axis_tready), 64'(exp_rdy));
        chk("m_tvalid", 64'(m_axis_tvalid), 64'(exp_vld));
        chk("fill_level", 64'(fill_level), 64'(q.size()));
        chk("pkt_count", 64'(pkt_count), 64'(lastcnt()));
        chk("cut_through", 64'(cut_through), 64'(m_cut));
        if (exp_vld) begin
            chk("m_tdata", 64'(m_axis_tdata), 64'(front[DW-1:0]));
            chk("m_tlast", 64'(m_axis_tlast), 64'(front[DW]));
        end
        did_wr  = vin && exp_rdy;
        did_rd  = exp_vld && rdy;
        nxt_cut = m_cut ? !(did_rd && front[DW]) : ((q.size() == DEPTH) && (lastcnt() == 0));
        @(posedge clk);
        if (did_rd) begin
            void'(q.pop_front());
            out_log.push_back(front);
        end
        if (did_wr) begin
            q.push_back({l, d});
            in_log.push_back({l, d});
        end
        m_cut = nxt_cut;
        @(negedge clk);
    endtask

    task automatic check_out(input string name, input logic [DW:0] exp[$]);
        chk({name, "_count"}, 64'(out_log.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < out_log.size(); i++) begin
            chk({name, "_beat"}, 64'(out_log[i]), 64'(exp[i]));
        end
    endtask

    initial begin
        logic [DW:0] exp_q[$];
        logic [DW-1:0] sd;
        logic          sl;
        bit            src_v;
        bit            seen_cut;
        int            b;
        int            k;
        int            left;

        for (int i = 0; i < 16; i++) begin
            tbl[i] = '{vin: 1'b1, d: DW'(i + 1), l: (i == 15), rdy: 1'b1,
                       e_vld: 1'b0, e_data: '0, e_last: 1'b0, e_fill: (AW+1)'(i), e_pkt: '0};
        end
        for (int j = 0; j < 16; j++) begin
            tbl[16 + j] = '{vin: 1'b0, d: '0, l: 1'b0, rdy: 1'b1,
                            e_vld: 1'b1, e_data: DW'(j + 1), e_last: (j == 15),
                            e_fill: (AW+1)'(16 - j), e_pkt: (AW+1)'(1)};
        end
        tbl[32] = '{vin: 1'b0, d: '0, l: 1'b0, rdy: 1'b1,
                    e_vld: 1'b0, e_data: '0, e_last: 1'b0, e_fill: '0, e_pkt: '0};

        reset = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        m_cut = 0;
        #3;
        chk("rst_s_tready", 64'(s_axis_tready), 64'(1));
        chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("rst_fill", 64'(fill_level), 64'(0));
        chk("rst_pkt", 64'(pkt_count), 64'(0));
        chk("rst_cut", 64'(cut_through), 64'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Single 16-beat packet: no output until tlast is stored, then 16 beats back to back.
        for (int i = 0; i < 33; i++) begin
            s_axis_tvalid = tbl[i].vin;
            s_axis_tdata  = tbl[i].d;
            s_axis_tlast  = tbl[i].l;
            m_axis_tready = tbl[i].rdy;
            #1;
            chk("t1_tvalid", 64'(m_axis_tvalid), 64'(tbl[i].e_vld));
            chk("t1_fill", 64'(fill_level), 64'(tbl[i].e_fill));
            chk("t1_pkt", 64'(pkt_count), 64'(tbl[i].e_pkt));
            if (tbl[i].e_vld) begin
                chk("t1_tdata", 64'(m_axis_tdata), 64'(tbl[i].e_data));
                chk("t1_tlast", 64'(m_axis_tlast), 64'(tbl[i].e_last));
            end
            step(tbl[i].vin, tbl[i].d, tbl[i].l, tbl[i].rdy);
        end

        // Upstream stalls mid-packet: still nothing out before tlast, then contiguous output.
        out_log.delete();
        exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            if (i >= 8 && i < 12) begin
                step(1'b0, '0, 1'b0, 1'b1);
            end else begin
                b = (i < 8) ? i : i - 4;
                step(1'b1, DW'(b + 1), (b == 15), 1'b1);
                exp_q.push_back({(b == 15), DW'(b + 1)});
            end
            chk("t2_no_early_out", 64'(did_rd), 64'(0));
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0, 1'b0, 1'b1);
            chk("t2_contiguous", 64'(did_rd), 64'(1));
        end
        check_out("t2_out", exp_q);

        // Two back-to-back packets with downstream ready 8 on / 4 off.
        out_log.delete();
        exp_q.delete();
        b = 0;
        k = 0;
        while (!(b == 32 && q.size() == 0) && k < 400) begin
            sd = (b < 16) ? DW'(b + 1) : DW'(32 - b);
            sl = (b == 15) || (b == 31);
            step((b < 32), sd, sl, ((k % 12) < 8));
            chk("t3_fill_max", 64'(fill_level <= (AW+1)'(DEPTH)), 64'(1));
            if (did_wr) begin
                exp_q.push_back({sl, sd});
                b++;
            end
            k++;
        end
        chk("t3_done_in_budget", 64'(k < 400), 64'(1));
        check_out("t3_out", exp_q);

        // Oversize 40-beat packet with downstream held off until the FIFO is full.
        out_log.delete();
        exp_q.delete();
        b = 0;
        k = 0;
        left = 0;
        seen_cut = 0;
        while (!(b == 40 && q.size() == 0) && k < 400) begin
            if (q.size() == DEPTH) left++;
            step((b < 40), DW'(b + 1), (b == 39), (left > 3));
            if (cut_through) seen_cut = 1;
            if (did_wr) begin
                exp_q.push_back({(b == 39), DW'(b + 1)});
                b++;
            end
            k++;
        end
        chk("t4_done_in_budget", 64'(k < 400), 64'(1));
        chk("t4_cut_seen", 64'(seen_cut), 64'(1));
        chk("t4_cut_cleared", 64'(cut_through), 64'(0));
        check_out("t4_out", exp_q);

        // Write tlast and read tlast in the same cycle with one packet stored.
        out_log.delete();
        step(1'b1, DW'('hA), 1'b1, 1'b0);
        step(1'b1, DW'('hB), 1'b1, 1'b1);
        chk("t5_both", 64'({did_wr, did_rd}), 64'(2'b11));
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        #1;
        chk("t5_pkt_stays_1", 64'(pkt_count), 64'(1));
        chk("t5_fill_stays_1", 64'(fill_level), 64'(1));
        step(1'b0, '0, 1'b0, 1'b1);
        exp_q.delete();
        exp_q.push_back({1'b1, DW'('hA)});
        exp_q.push_back({1'b1, DW'('hB)});
        check_out("t5_out", exp_q);

        // Asynchronous reset mid-packet with ten words stored.
        for (int i = 0; i < 10; i++) step(1'b1, DW'('h50 + i), 1'b0, 1'b1);
        chk("t6_fill_pre", 64'(fill_level), 64'(10));
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_fill", 64'(fill_level), 64'(0));
        chk("t6_rst_pkt", 64'(pkt_count), 64'(0));
        chk("t6_rst_cut", 64'(cut_through), 64'(0));
        chk("t6_rst_tready", 64'(s_axis_tready), 64'(1));
        chk("t6_rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        q.delete();
        m_cut = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        out_log.delete();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, DW'('hC0 + i), (i == 3), 1'b1);
            exp_q.push_back({(i == 3), DW'('hC0 + i)});
        end
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, 1'b1);
        check_out("t6_out", exp_q);

        // Random packets and random backpressure; everything written must come out in order.
        out_log.delete();
        in_log.delete();
        src_v = 0;
        sd = '0;
        sl = 0;
        left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!src_v && $urandom_range(0, 3) != 0) begin
                if (left == 0) left = $urandom_range(1, 40);
                src_v = 1;
                sd = $urandom;
                sl = (left == 1);
            end
            step(src_v, sd, sl, (i % 500 < 250) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
            if (did_wr) begin
                src_v = 0;
                left--;
            end
        end
        k = 0;
        while (!(left == 0 && !src_v && q.size() == 0) && k < 400) begin
            if (!src_v && left > 0) begin
                src_v = 1;
                sd = $urandom;
                sl = (left == 1);
            end
            step(src_v, sd, sl, 1'b1);
            if (did_wr) begin
                src_v = 0;
                left--;
            end
            k++;
        end
        chk("rand_drain_in_budget", 64'(k < 400), 64'(1));
        check_out("rand_out", in_log);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
